// File: rtl/switch4_sched_pkg.sv
// Shared types and constants for the 4-port burst scheduler.
// A mode m routes input i to output i XOR m.
package switch4_sched_pkg;
  localparam int NPORTS = 4;

  typedef enum logic {IDLE, BURST} state_t;
  typedef logic [1:0] mode_t;

  // Mode under which input 'port' reaches output 'dest'.
  function automatic mode_t mode_for(input logic [1:0] dest, input int port);
    return dest ^ mode_t'(port);
  endfunction
endpackage

// File: rtl/switch4_sched_if.sv
// Request/grant bundle between the requesting input ports and the scheduler.
// master = requesters, slave = scheduler.
interface switch4_sched_if;
  import switch4_sched_pkg::*;

  logic [NPORTS-1:0]   req_valid;
  logic [2*NPORTS-1:0] req_dest;
  logic [4*NPORTS-1:0] req_len;
  logic                sel0;
  logic                sel1;
  logic [NPORTS-1:0]   grant;
  logic [NPORTS-1:0]   active;
  logic                busy;

  modport master (
    output req_valid, req_dest, req_len,
    input  sel0, sel1, grant, active, busy
  );

  modport slave (
    input  req_valid, req_dest, req_len,
    output sel0, sel1, grant, active, busy
  );
endinterface

// File: rtl/switch4_sched_mode_scorer.sv
// Combinational mode picker: satisfiable count per mode, round-robin tie break,
// and a starvation override that forces the mode of the lowest starved port.
module mode_scorer
  import switch4_sched_pkg::*;
(
  input  logic [NPORTS-1:0]   req_valid,
  input  logic [2*NPORTS-1:0] req_dest,
  input  mode_t               rr_ptr,
  input  logic [NPORTS-1:0]   starve,
  output mode_t               pick,
  output logic [NPORTS-1:0]   mask
);
  logic [NPORTS-1:0] sat [NPORTS];
  logic [2:0]        cnt [NPORTS];
  mode_t             best;
  mode_t             cand;
  mode_t             forced_mode;
  logic              forced;

  always_comb begin
    for (int m = 0; m < NPORTS; m++) begin
      cnt[m] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        sat[m][i] = req_valid[i] && (mode_for(req_dest[2*i +: 2], i) == mode_t'(m));
        cnt[m]    = cnt[m] + {2'b00, sat[m][i]};
      end
    end

    // Strict '>' keeps the earliest mode in search order on ties.
    best = rr_ptr;
    cand = rr_ptr;
    for (int k = 1; k < NPORTS; k++) begin
      cand = rr_ptr + mode_t'(k);
      if (cnt[cand] > cnt[best]) best = cand;
    end

    forced      = 1'b0;
    forced_mode = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (starve[i]) begin
        forced      = 1'b1;
        forced_mode = mode_for(req_dest[2*i +: 2], i);
      end
    end

    pick = forced ? forced_mode : best;
    mask = sat[pick];
  end
endmodule

// File: rtl/switch4_sched.sv
// Burst scheduler for a 4x4 XOR-routed switch: picks a mode in IDLE, holds it
// for the longest granted burst, then returns to IDLE for at least one cycle.
module switch4_sched
  import switch4_sched_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic           clk,
  input  logic           reset,
  switch4_sched_if.slave io
);
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t            state;
  mode_t             rr_ptr;
  mode_t             pick;
  logic [3:0]        beats;
  logic [3:0]        wait_cnt [NPORTS];
  logic [NPORTS-1:0] starve;
  logic [NPORTS-1:0] mask;
  logic [NPORTS-1:0] grant_q;
  logic [NPORTS-1:0] active_q;
  logic              sel0_q;
  logic              sel1_q;
  logic              busy_q;
  logic [3:0]        max_len;

  always_comb begin
    max_len = '0;
    for (int i = 0; i < NPORTS; i++) begin
      starve[i] = io.req_valid[i] && (wait_cnt[i] == WAIT_MAX);
      if (mask[i] && (io.req_len[4*i +: 4] > max_len)) max_len = io.req_len[4*i +: 4];
    end
  end

  mode_scorer u_scorer (
    .req_valid (io.req_valid),
    .req_dest  (io.req_dest),
    .rr_ptr    (rr_ptr),
    .starve    (starve),
    .pick      (pick),
    .mask      (mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      beats    <= '0;
      grant_q  <= '0;
      active_q <= '0;
      sel0_q   <= 1'b0;
      sel1_q   <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < NPORTS; i++) wait_cnt[i] <= '0;
    end else begin
      grant_q <= '0;
      case (state)
        IDLE: begin
          if (|io.req_valid) begin
            sel0_q   <= pick[1];
            sel1_q   <= pick[0];
            grant_q  <= mask;
            active_q <= mask;
            busy_q   <= 1'b1;
            beats    <= max_len;
            rr_ptr   <= pick + 2'd1;
            state    <= BURST;
          end
        end
        BURST: begin
          if (beats == '0) begin
            active_q <= '0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else begin
            beats <= beats - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // Waits only age during an IDLE arbitration; they hold through bursts.
      for (int i = 0; i < NPORTS; i++) begin
        if (!io.req_valid[i]) begin
          wait_cnt[i] <= '0;
        end else if (state == IDLE) begin
          if (mask[i])                     wait_cnt[i] <= '0;
          else if (wait_cnt[i] != WAIT_MAX) wait_cnt[i] <= wait_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign io.sel0   = sel0_q;
  assign io.sel1   = sel1_q;
  assign io.grant  = grant_q;
  assign io.active = active_q;
  assign io.busy   = busy_q;
endmodule

// File: tb/tb_switch4_sched.sv
// Bench for switch4_sched: directed scenarios then random traffic, every cycle
// compared with a transaction-level model of the scheduling rules.
module tb_switch4_sched;
  localparam int MW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  switch4_sched_if sif ();

  switch4_sched #(.MAX_WAIT(MW)) dut (
    .clk   (clk),
    .reset (rst),
    .io    (sif)
  );

  always #5 clk = ~clk;

  // Model state: remaining busy cycles, round-robin start, per-port lost rounds.
  int         m_rem;
  int         m_rr;
  int         m_wait [4];
  logic [3:0] e_grant;
  logic [3:0] e_active;
  logic       e_busy;
  logic [1:0] e_sel;

  function automatic int dst(int i);
    return int'(sif.req_dest[2*i +: 2]);
  endfunction

  function automatic int len_of(int i);
    return int'(sif.req_len[4*i +: 4]);
  endfunction

  task automatic model_step();
    int cnt [4];
    int top;
    int mode;
    int forced;
    int ml;
    logic [3:0] gm;
    if (rst) begin
      m_rem = 0; m_rr = 0;
      for (int i = 0; i < 4; i++) m_wait[i] = 0;
      e_grant = '0; e_active = '0; e_busy = 1'b0; e_sel = 2'b00;
      return;
    end
    e_grant = '0;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin e_active = '0; e_busy = 1'b0; end
      for (int i = 0; i < 4; i++) if (!sif.req_valid[i]) m_wait[i] = 0;
    end else if (sif.req_valid != 4'b0) begin
      top = 0;
      for (int m = 0; m < 4; m++) begin
        cnt[m] = 0;
        for (int i = 0; i < 4; i++) if (sif.req_valid[i] && dst(i) == (i ^ m)) cnt[m]++;
        if (cnt[m] > top) top = cnt[m];
      end
      mode = -1;
      for (int k = 0; k < 4; k++) if (mode < 0 && cnt[(m_rr + k) % 4] == top) mode = (m_rr + k) % 4;
      forced = -1;
      for (int i = 0; i < 4; i++) if (forced < 0 && sif.req_valid[i] && m_wait[i] == MW) forced = i;
      if (forced >= 0) mode = dst(forced) ^ forced;
      gm = '0; ml = 0;
      for (int i = 0; i < 4; i++) begin
        if (sif.req_valid[i] && dst(i) == (i ^ mode)) begin
          gm[i] = 1'b1;
          if (len_of(i) > ml) ml = len_of(i);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!sif.req_valid[i] || gm[i]) m_wait[i] = 0;
        else if (m_wait[i] < MW) m_wait[i]++;
      end
      e_grant = gm; e_active = gm; e_busy = 1'b1; e_sel = 2'(mode);
      m_rr = (mode + 1) % 4;
      m_rem = ml + 1;
    end else begin
      for (int i = 0; i < 4; i++) m_wait[i] = 0;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("grant", sif.grant, e_grant);
    check("active", sif.active, e_active);
    check("busy", {3'b000, sif.busy}, {3'b000, e_busy});
    check("sel", {2'b00, sif.sel0, sif.sel1}, {2'b00, e_sel});
  endtask

  function automatic logic [1:0] sel_now();
    return {sif.sel0, sif.sel1};
  endfunction

  initial begin
    sif.req_valid = '0;
    sif.req_dest  = '0;
    sif.req_len   = '0;

    // Reset state
    rst = 1'b1; cyc();
    check("rst_busy", {3'b000, sif.busy}, 4'b0000);
    check("rst_sel", {2'b00, sel_now()}, 4'b0000);
    rst = 1'b0;

    // All ports straight through, single-beat bursts
    sif.req_valid = 4'b1111; sif.req_dest = 8'b11_10_01_00; sif.req_len = 16'h0000;
    cyc();
    check("id_grant", sif.grant, 4'b1111);
    check("id_sel", {2'b00, sel_now()}, 4'b0000);
    sif.req_valid = 4'b0000;
    cyc();
    check("id_busy_end", {3'b000, sif.busy}, 4'b0000);

    // Port 0 to output 3, 3-beat burst
    sif.req_valid = 4'b0001; sif.req_dest = 8'h03; sif.req_len = 16'h0002;
    cyc();
    check("rev_grant", sif.grant, 4'b0001);
    check("rev_sel", {2'b00, sel_now()}, 4'b0011);
    sif.req_valid = 4'b0000;
    cyc(); cyc();
    check("rev_active3", sif.active, 4'b0001);
    cyc();
    check("rev_busy4", {3'b000, sif.busy}, 4'b0000);

    // Round-robin tie break
    rst = 1'b1; cyc(); rst = 1'b0;
    sif.req_valid = 4'b0011; sif.req_dest = 8'h00; sif.req_len = 16'h0000;
    cyc();
    check("tie_first", sif.grant, 4'b0001);
    sif.req_valid = 4'b0010;
    cyc(); cyc();
    check("tie_second", sif.grant, 4'b0010);
    check("tie_sel", {2'b00, sel_now()}, 4'b0001);
    sif.req_valid = 4'b0000;
    cyc();

    // Starvation override on the third arbitration
    rst = 1'b1; cyc(); rst = 1'b0;
    sif.req_valid = 4'b1111; sif.req_dest = 8'b11_10_01_11; sif.req_len = 16'h0000;
    cyc();
    check("starve_arb1", sif.grant, 4'b1110);
    cyc(); cyc();
    check("starve_arb2", sif.grant, 4'b1110);
    cyc(); cyc();
    check("starve_arb3", sif.grant, 4'b0001);
    check("starve_sel", {2'b00, sel_now()}, 4'b0011);
    sif.req_valid = 4'b0000;
    cyc(); cyc();

    // Reset during the second beat of a long burst
    sif.req_valid = 4'b0001; sif.req_dest = 8'h03; sif.req_len = 16'h0005;
    cyc();
    sif.req_valid = 4'b0000;
    cyc();
    rst = 1'b1;
    cyc();
    check("mid_rst_busy", {3'b000, sif.busy}, 4'b0000);
    check("mid_rst_active", sif.active, 4'b0000);
    check("mid_rst_grant", sif.grant, 4'b0000);
    check("mid_rst_sel", {2'b00, sel_now()}, 4'b0000);
    rst = 1'b0;

    // Destination change during a burst must not move the selects
    sif.req_valid = 4'b0001; sif.req_dest = 8'h01; sif.req_len = 16'h0004;
    cyc();
    check("hold_sel0", {2'b00, sel_now()}, 4'b0001);
    sif.req_dest = 8'h02;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("hold_sel", {2'b00, sel_now()}, 4'b0001);
    end
    cyc();
    check("hold_new_sel", {2'b00, sel_now()}, 4'b0010);
    sif.req_valid = 4'b0000;
    cyc();

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        sif.req_valid = 4'($urandom);
        sif.req_dest  = 8'($urandom);
        sif.req_len   = 16'($urandom) & 16'h3333;
      end
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/switch4_sched.md
SWITCH4_SCHED -- requirements
Module: switch4_sched

Interface
REQ-001 Parameter: MAX_WAIT, 8, arbitration rounds a valid requester may lose before it is force-served (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  4  bit i: input port i has a pending burst.
REQ-005 req_dest  input  8  bits [2i+1:2i]: destination output port of input i.
REQ-006 req_len  input  16  bits [4i+3:4i]: burst length minus one (1..16 beats) of input i.
REQ-007 sel0  output  1  stage-1 select of the 4x4 switch network; registered.
REQ-008 sel1  output  1  stage-2 select of the 4x4 switch network; registered.
REQ-009 grant  output  4  one-cycle pulse: bit i, burst of input i accepted.
REQ-010 active  output  4  bit i: input i is connected for the current burst.
REQ-011 busy  output  1  high while in BURST.

Function
REQ-012 Routing model: mode m = {sel0,sel1}; input i reaches output i XOR m (m=0 identity, 1 swap pairs, 2 swap halves, 3 reverse).
REQ-013 Requester i is satisfiable by mode m when req_valid[i]=1 and req_dest[i] = i XOR m.
REQ-014 FSM states: IDLE, BURST; reset state IDLE.
REQ-015 IDLE, req_valid=0: stay IDLE; sel0/sel1 hold their last value; grant=0, active=0.
REQ-016 IDLE, req_valid!=0: select mode, register sel0/sel1, pulse grant for all satisfiable requesters, set active to the same mask, load beat counter with the maximum req_len among granted ports, go to BURST (grant visible 1 cycle after request seen).
REQ-017 Mode selection: the mode with the highest satisfiable count; ties are broken round-robin, searching from rr_ptr upward modulo 4; rr_ptr becomes chosen mode + 1 after every grant.
REQ-018 Starvation: each port has a 4-bit wait counter, incremented in every IDLE arbitration cycle where the port is valid and not granted, saturating at MAX_WAIT; cleared on grant or when valid is low.
REQ-019 If any wait counter equals MAX_WAIT, the chosen mode is forced to req_dest[i] XOR i of the lowest-index such port, overriding REQ-017; rr_ptr still updates.
REQ-020 BURST: counter decrements each cycle; at counter=0 clear active and busy and return to IDLE; burst occupies len+1 cycles; one IDLE cycle always separates bursts.
REQ-021 sel0/sel1 SHALL NOT change outside the IDLE-to-BURST transition.
REQ-022 Requesters hold valid/dest/len stable until grant; new request values are sampled the cycle after grant at the earliest; req_* changes during BURST are ignored.
REQ-023 A requester whose bit in req_valid is 0 is never granted, irrespective of req_dest.

Reset
REQ-024 Reset sets state IDLE, sel0=0, sel1=0, grant=0, active=0, busy=0, rr_ptr=0, beat counter=0, all wait counters=0.
REQ-025 Reset asserted mid-burst takes effect at the next edge and discards the burst; no grant is issued in that cycle.

Structure
REQ-026 Package switch4_sched_pkg SHALL hold the state enum, the 2-bit mode typedef, and the port-count constant (4).
REQ-027 Sub-module mode_scorer (combinational) SHALL compute the four satisfiable counts and the round-robin/forced pick; switch4_sched holds FSM, counters, and registers.
REQ-028 switch4_sched SHALL NOT instantiate the switch network; the parent wires sel0/sel1 to it.

Verification
REQ-029 After reset: valid=1111, dest=(0,1,2,3), len=0 for all ports -> next cycle sel={0,0}, grant=1111, busy for 1 cycle, then IDLE.
REQ-030 valid=0001 dest0=3 len0=2 -> sel={1,1}, grant=0001, active=0001 for 3 cycles, busy deasserts on the 4th.
REQ-031 Tie: valid=0011, dest0=0, dest1=0, rr_ptr=0 -> mode 0 (grant 0001); re-request port 1 -> mode 1 (grant 0010).
REQ-032 Starvation, MAX_WAIT=2: ports 1..3 keep winning mode 0 while port 0 requests dest 3 -> port 0 is granted with sel={1,1} on its 3rd arbitration.
REQ-033 Reset asserted in the 2nd beat of a len=5 burst -> next cycle busy=0, active=0, sel={0,0}, no grant pulse.
REQ-034 Changing req_dest during BURST -> sel0/sel1 unchanged until the next IDLE-to-BURST transition.
